// File: rtl/quantum_dispatcher_if.sv
// Word-stream handshake and per-channel FIFO read bus of the quantum dispatcher.
// master = stream source / channel consumers, slave = dispatcher.
interface quantum_dispatcher_if #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8
);
  localparam int SELW = $clog2(NUM_REQS);

  logic                      push;
  logic [WIDTH-1:0]          data_in;
  logic                      ready;
  logic [SELW-1:0]           sel;
  logic [NUM_REQS-1:0]       pop;
  logic [NUM_REQS*WIDTH-1:0] flat_data_out;
  logic [NUM_REQS-1:0]       empty;
  logic [NUM_REQS-1:0]       full;

  modport master (
    output push, data_in, pop,
    input  ready, sel, flat_data_out, empty, full
  );

  modport slave (
    input  push, data_in, pop,
    output ready, sel, flat_data_out, empty, full
  );
endinterface

// File: rtl/quantum_dispatcher.sv
// Weighted round-robin dispatcher of one word stream into NUM_REQS fall-through FIFOs.
// Optional DISPATCH_SKIP_FULL_EN: a full current channel forfeits its quantum instead of stalling.
module quantum_dispatcher #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int QWID     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS*QWID-1:0] quantums,
  quantum_dispatcher_if.slave      bus
);
  localparam int SELW = $clog2(NUM_REQS);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int QW1  = QWID + 1;

  logic [SELW-1:0]     ptr;
  logic [SELW-1:0]     ptr_next;
  logic [QWID-1:0]     cnt;
  logic [QWID-1:0]     q_raw;
  logic [QWID-1:0]     q_eff;
  logic                burst_done;
  logic                ptr_full;
  logic                accept;
  logic [NUM_REQS-1:0] empty;
  logic [NUM_REQS-1:0] full;

  always_comb begin
    q_raw = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (ptr == SELW'(i)) q_raw = quantums[i*QWID +: QWID];
    end
  end

  // A zero quantum still grants one word so the channel is never starved.
  assign q_eff      = (q_raw == '0) ? QWID'(1) : q_raw;
  assign burst_done = ({1'b0, cnt} + QW1'(1)) >= {1'b0, q_eff};
  assign ptr_next   = (ptr == SELW'(NUM_REQS - 1)) ? '0 : ptr + SELW'(1);
  assign ptr_full   = full[ptr];
  assign bus.ready  = rst & ~ptr_full;
  assign accept     = bus.push & bus.ready;
  assign bus.sel    = ptr;
  assign bus.empty  = empty;
  assign bus.full   = full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (burst_done) begin
        ptr <= ptr_next;
        cnt <= '0;
      end else begin
        cnt <= cnt + QWID'(1);
      end
`ifdef DISPATCH_SKIP_FULL_EN
    end else if (ptr_full) begin
      ptr <= ptr_next;
      cnt <= '0;
`endif
    end
  end

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             wr_en;
    logic             rd_en;

    assign wr_en    = accept & (ptr == SELW'(g));
    // Gating on empty makes a pop alongside a push into an empty FIFO a no-op.
    assign rd_en    = bus.pop[g] & ~empty[g];
    assign empty[g] = (occ == '0);
    assign full[g]  = (occ == CW'(DEPTH));
    assign bus.flat_data_out[g*WIDTH +: WIDTH] = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      end else begin
        if (wr_en) begin
          mem[wr_ptr] <= bus.data_in;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        if (wr_en && !rd_en)      occ <= occ + CW'(1);
        else if (!wr_en && rd_en) occ <= occ - CW'(1);
      end
    end
  end
endmodule
